// File: rtl/uart_ram_loader.sv
// Boot loader: receives a framed program image over 8N1 UART, writes 16-bit words
// into the program RAM, verifies an 8-bit checksum, then releases the CPU from reset.
module uart_ram_loader #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_wdata,
  output logic        cpu_rst_n,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC + 1);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    L_IDLE = 3'd0,
    L_LEN  = 3'd1,
    L_HI   = 3'd2,
    L_LO   = 3'd3,
    L_CSUM = 3'd4,
    L_DONE = 3'd5,
    L_ERR  = 3'd6
  } ld_state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction

  logic            rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t       rx_state_r, rx_state_s;
  logic [CW-1:0]   rx_cnt_r, rx_cnt_s;
  logic [2:0]      rx_bit_r, rx_bit_s;
  logic [7:0]      rx_shift_r, rx_shift_s;
  logic [7:0]      rx_byte_r, rx_byte_s;
  logic            rx_valid_r, rx_valid_s;
  logic            rx_ferr_r, rx_ferr_s;

  ld_state_t       ld_state_r, ld_state_s;
  logic [8:0]      wcnt_r, wcnt_s, wcnt_inc_s;
  logic [8:0]      nwords_r, nwords_s;
  logic [7:0]      csum_r, csum_s;
  logic [7:0]      hi_r, hi_s;
  logic            ram_we_r, ram_we_s;
  logic [7:0]      ram_addr_r, ram_addr_s;
  logic [15:0]     ram_wdata_r, ram_wdata_s;
  logic            cpu_rst_n_r, cpu_rst_n_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            err_r, err_s;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver next-state: mid-bit sampling, glitch rejection on the start bit.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r + CNT_ONE;
    rx_bit_s   = rx_bit_r;
    rx_shift_s = rx_shift_r;
    rx_byte_s  = rx_byte_r;
    rx_valid_s = 1'b0;
    rx_ferr_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = CNT_ZERO;
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_s = CNT_ZERO;
          rx_bit_s = 3'd0;
          if (rx_sync_r) begin
            rx_state_s = RX_IDLE;
          end else begin
            rx_state_s = RX_DATA;
          end
        end else begin
          rx_state_s = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            rx_bit_s = rx_bit_r + 3'd1;
          end
        end else begin
          rx_state_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_state_s = RX_IDLE;
          if (rx_sync_r) begin
            rx_valid_s = 1'b1;
            rx_byte_s  = rx_shift_r;
          end else begin
            rx_ferr_s = 1'b1;
          end
        end else begin
          rx_state_s = RX_STOP;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= CNT_ZERO;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
      rx_byte_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
      rx_byte_r  <= rx_byte_s;
      rx_valid_r <= rx_valid_s;
      rx_ferr_r  <= rx_ferr_s;
    end
  end

  // Loader next-state; a framing error mid-frame overrides any byte handling.
  always_comb begin
    ld_state_s  = ld_state_r;
    wcnt_s      = wcnt_r;
    nwords_s    = nwords_r;
    csum_s      = csum_r;
    hi_s        = hi_r;
    ram_we_s    = 1'b0;
    ram_addr_s  = ram_addr_r;
    ram_wdata_s = ram_wdata_r;
    cpu_rst_n_s = cpu_rst_n_r;
    busy_s      = busy_r;
    done_s      = done_r;
    err_s       = err_r;
    wcnt_inc_s  = wcnt_r + 9'd1;
    if (rx_ferr_r && busy_r) begin
      ld_state_s  = L_ERR;
      err_s       = 1'b1;
      done_s      = 1'b0;
      busy_s      = 1'b0;
      cpu_rst_n_s = 1'b0;
    end else begin
      case (ld_state_r)
        L_IDLE, L_DONE, L_ERR: begin
          if (rx_valid_r && (rx_byte_r == SYNC_BYTE)) begin
            ld_state_s  = L_LEN;
            wcnt_s      = 9'd0;
            csum_s      = 8'd0;
            cpu_rst_n_s = 1'b0;
            busy_s      = 1'b1;
            done_s      = 1'b0;
            err_s       = 1'b0;
          end else begin
            ld_state_s = ld_state_r;
          end
        end
        L_LEN: begin
          if (rx_valid_r) begin
            nwords_s   = (rx_byte_r == 8'd0) ? 9'd256 : {1'b0, rx_byte_r};
            ld_state_s = L_HI;
          end else begin
            ld_state_s = L_LEN;
          end
        end
        L_HI: begin
          if (rx_valid_r) begin
            hi_s       = rx_byte_r;
            csum_s     = csum_add(csum_r, rx_byte_r);
            ld_state_s = L_LO;
          end else begin
            ld_state_s = L_HI;
          end
        end
        L_LO: begin
          if (rx_valid_r) begin
            ram_we_s    = 1'b1;
            ram_addr_s  = wcnt_r[7:0];
            ram_wdata_s = {hi_r, rx_byte_r};
            csum_s      = csum_add(csum_r, rx_byte_r);
            wcnt_s      = wcnt_inc_s;
            if (wcnt_inc_s == nwords_r) begin
              ld_state_s = L_CSUM;
            end else begin
              ld_state_s = L_HI;
            end
          end else begin
            ld_state_s = L_LO;
          end
        end
        L_CSUM: begin
          if (rx_valid_r) begin
            busy_s = 1'b0;
            if (rx_byte_r == csum_r) begin
              ld_state_s  = L_DONE;
              done_s      = 1'b1;
              cpu_rst_n_s = 1'b1;
            end else begin
              ld_state_s  = L_ERR;
              err_s       = 1'b1;
              cpu_rst_n_s = 1'b0;
            end
          end else begin
            ld_state_s = L_CSUM;
          end
        end
        default: begin
          ld_state_s  = L_IDLE;
          busy_s      = 1'b0;
          cpu_rst_n_s = 1'b0;
        end
      endcase
    end
  end

  // Loader state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_state_r  <= L_IDLE;
      wcnt_r      <= 9'd0;
      nwords_r    <= 9'd0;
      csum_r      <= 8'd0;
      hi_r        <= 8'd0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= 8'd0;
      ram_wdata_r <= 16'd0;
      cpu_rst_n_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      ld_state_r  <= ld_state_s;
      wcnt_r      <= wcnt_s;
      nwords_r    <= nwords_s;
      csum_r      <= csum_s;
      hi_r        <= hi_s;
      ram_we_r    <= ram_we_s;
      ram_addr_r  <= ram_addr_s;
      ram_wdata_r <= ram_wdata_s;
      cpu_rst_n_r <= cpu_rst_n_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  assign ram_we    = ram_we_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign cpu_rst_n = cpu_rst_n_r;
  assign load_busy = busy_r;
  assign load_done = done_r;
  assign load_err  = err_r;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Scoreboard bench for uart_ram_loader: frames are built at byte level, expected
// RAM writes are queued as they are issued and checked by an independent monitor.
module tb_uart_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        cpu_rst_n;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  int total = 0;
  int bad = 0;
  logic [23:0] exp_q[$];
  logic [15:0] words[256];
  bit          chk_drop = 1'b0;

  always #5 clk = ~clk;

  uart_ram_loader #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_rst_n(cpu_rst_n), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [23:0] e;
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write", 32'({ram_addr, ram_wdata}), 32'(e));
      end
    end
  end

  // 8N1 byte at 16 clocks per bit; optional bad stop bit and shortened stop.
  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int stop_len);
    int cyc;
    logic v;
    int len;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) v = 1'b0;
      else if (i == 9) v = ~bad_stop;
      else v = b[i-1];
      len = (i == 9) ? stop_len : 16;
      uart_rx = v;
      repeat (len) begin
        @(negedge clk);
        cyc++;
        if (chk_drop && cyc == 150) check("cpu_hold_before_sync", 32'(cpu_rst_n), 32'd1);
      end
    end
    uart_rx = 1'b1;
    if (chk_drop) check("cpu_drop_after_sync", 32'(cpu_rst_n), 32'd0);
  endtask

  task automatic glitch();
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
  endtask

  // Sends one frame from words[]; the model derives writes and final status.
  task automatic send_frame(input logic [7:0] len, input bit bad_csum, input int ferr_idx,
                            input bit glitch_mid, input bit drop_chk, input int stop_len);
    int n;
    int di;
    bit ferr_hit;
    logic [7:0] sum;
    logic [7:0] b;
    n = (len == 8'd0) ? 256 : int'(len);
    di = 0;
    ferr_hit = 1'b0;
    sum = 8'd0;
    chk_drop = drop_chk;
    send_byte(8'hA5, 1'b0, 16);
    chk_drop = 1'b0;
    send_byte(len, 1'b0, stop_len);
    for (int w = 0; w < n; w++) begin
      for (int h = 0; h < 2; h++) begin
        b = (h == 0) ? words[w][15:8] : words[w][7:0];
        if (di == ferr_idx) begin
          send_byte(b, 1'b1, 16);
          ferr_hit = 1'b1;
          repeat (20) @(negedge clk);
          check("ferr_err", 32'(load_err), 32'd1);
          check("ferr_busy", 32'(load_busy), 32'd0);
        end else begin
          if (h == 1 && !ferr_hit) exp_q.push_back({w[7:0], words[w]});
          send_byte(b, 1'b0, stop_len);
        end
        sum += b;
        di++;
        if (glitch_mid && w == 0 && h == 0) glitch();
      end
    end
    send_byte(bad_csum ? sum + 8'd1 : sum, 1'b0, stop_len);
    repeat (30) @(negedge clk);
    check("end_busy", 32'(load_busy), 32'd0);
    if (ferr_hit || bad_csum) begin
      check("end_err", 32'(load_err), 32'd1);
      check("end_done", 32'(load_done), 32'd0);
      check("end_cpu", 32'(cpu_rst_n), 32'd0);
    end else begin
      check("end_err", 32'(load_err), 32'd0);
      check("end_done", 32'(load_done), 32'd1);
      check("end_cpu", 32'(cpu_rst_n), 32'd1);
    end
  endtask

  task automatic set_fixed();
    words[0] = 16'h1234;
    words[1] = 16'h0001;
    words[2] = 16'hFFFE;
  endtask

  initial begin
    int rl;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_cpu", 32'(cpu_rst_n), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_busy", 32'(load_busy), 32'd0);

    set_fixed();
    send_frame(8'd3, 1'b0, -1, 1'b0, 1'b0, 16);
    send_frame(8'd3, 1'b1, -1, 1'b0, 1'b0, 16);
    send_frame(8'd3, 1'b0, -1, 1'b0, 1'b0, 16);
    send_frame(8'd3, 1'b0, 1, 1'b0, 1'b0, 16);

    for (int r = 0; r < 2; r++) begin
      rl = int'($urandom_range(1, 3));
      for (int i = 0; i < rl; i++) words[i] = 16'($urandom);
      send_frame(8'(rl), 1'($urandom), -1, 1'b0, 1'b0, 16);
    end

    for (int i = 0; i < 256; i++) words[i] = 16'(i);
    send_frame(8'd0, 1'b0, -1, 1'b0, 1'b0, 12);

    glitch();
    check("glitch_busy", 32'(load_busy), 32'd0);
    check("glitch_done", 32'(load_done), 32'd1);
    send_byte(8'h00, 1'b0, 16);
    send_byte(8'h5A, 1'b0, 16);
    repeat (20) @(negedge clk);
    check("junk_busy", 32'(load_busy), 32'd0);
    check("junk_done", 32'(load_done), 32'd1);
    words[0] = 16'($urandom);
    words[1] = 16'($urandom);
    send_frame(8'd2, 1'b0, -1, 1'b1, 1'b1, 16);

    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
